// File: rtl/imem_loader.sv
// imem_loader
// Fills the byte-addressed instruction memory from a framed byte stream
// while holding the core in reset.
//
// Frame layout: 4-byte length (LSB first), <length> payload bytes, and
// 1 checksum byte. The checksum is the mod-256 sum of the payload bytes.
// Payload byte n is written to BASE_ADDR + n.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse that begins a load (ignored unless idle)
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (independent of in_valid)
//   mem_we     IMEM byte write enable (one cycle per payload byte)
//   mem_addr   IMEM byte address
//   mem_wdata  IMEM byte data
//   busy       load in progress (length, data or checksum phase)
//   done       sticky: last load completed with a good checksum
//   error      sticky: last load failed (length or checksum)
//   cpu_hold   core reset request, busy OR rst
module imem_loader #(
    parameter int unsigned MEM_NBYTE = 4096,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest payload that fits between BASE_ADDR and the end of memory.
    localparam logic [31:0] LIMIT = 32'(MEM_NBYTE - BASE_ADDR);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);

    state_t      state;
    logic [31:0] len;       // payload length, shifted in LSB first
    logic [1:0]  len_cnt;   // length bytes received so far
    logic [31:0] idx;       // payload bytes received so far
    logic [7:0]  csum;      // running mod-256 payload sum

    logic        accept;
    logic [31:0] len_next;

    // busy is high exactly in LEN/DATA/CSUM, which are the accepting states,
    // so in_ready is simply the registered busy flag.
    assign in_ready = busy;
    assign accept   = in_valid && busy;
    assign cpu_hold = busy | rst;

    // Length value once the current byte has been shifted in at the top.
    assign len_next = {in_data, len[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len       <= '0;
            len_cnt   <= '0;
            idx       <= '0;
            csum      <= '0;
        end else begin
            mem_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LEN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        len     <= '0;
                        len_cnt <= '0;
                        idx     <= '0;
                        csum    <= '0;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        len     <= len_next;
                        len_cnt <= len_cnt + 2'd1;
                        if (len_cnt == 2'd3) begin
                            // Full 32-bit compare: any set upper bit rejects.
                            if (len_next > LIMIT) begin
                                state <= S_ERR;
                                busy  <= 1'b0;
                                error <= 1'b1;
                            end else if (len_next == '0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + idx;
                        mem_wdata <= in_data;
                        csum      <= csum + in_data;
                        idx       <= idx + 32'd1;
                        if (idx + 32'd1 == len) begin
                            state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end

                S_DONE: state <= S_IDLE;

                S_ERR: state <= S_IDLE;

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of framed loads with hand-computed
// outcomes, plus directed sequences for start-while-busy, reset mid-load
// and a full-memory load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(
        .MEM_NBYTE(4096),
        .BASE_ADDR(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Write log captured away from the active edge.
    int unsigned cyc = 0;
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int unsigned wc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%0b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0]  len;
        logic [7:0]   npay;
        logic [127:0] pay;
        logic         send_csum;
        logic [7:0]   csum;
        logic         gaps;
        logic         exp_done;
        logic         exp_err;
        logic [15:0]  exp_wr;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    initial begin
        int errs;
        int unsigned i;

        // len, npay, payload (byte0 in bits 7:0), send_csum, csum, gaps, done, err, writes
        vecs[0] = '{32'd8, 8'd8, 128'h0050_0093_0000_0013, 1'b1, 8'hF6, 1'b0, 1'b1, 1'b0, 16'd8};
        vecs[1] = '{32'd8, 8'd8, 128'h0050_0093_0000_0013, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd8};
        vecs[2] = '{32'h0000_1001, 8'd0, 128'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{32'h0100_0000, 8'd0, 128'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{32'd0, 8'd0, 128'h0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[5] = '{32'd16, 8'd16, 128'h100F0E0D_0C0B0A09_08070605_04030201, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 16'd16};
        vecs[6] = '{32'd3, 8'd3, 128'h00FF_FFFF, 1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 16'd3};
        vecs[7] = '{32'd1, 8'd1, 128'h80, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 16'd1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cpu_hold", cpu_hold, 0);

        // ---- table-driven frames ----
        for (int v = 0; v < NVEC; v++) begin
            wa.delete(); wd.delete(); wc.delete();
            pulse_start();
            chk($sformatf("v%0d_busy_len", v), busy, 1);
            chk($sformatf("v%0d_hold_len", v), cpu_hold, 1);
            chk($sformatf("v%0d_ready_len", v), in_ready, 1);
            for (int b = 0; b < 4; b++) send(vecs[v].len[8*b +: 8]);
            if (!vecs[v].send_csum) begin
                chk($sformatf("v%0d_err_after_len", v), error, 1);
                chk($sformatf("v%0d_ready_after_len", v), in_ready, 0);
            end else begin
                for (int b = 0; b < int'(vecs[v].npay); b++) begin
                    if (vecs[v].gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(vecs[v].pay[8*b +: 8]);
                end
                send(vecs[v].csum);
            end
            chk($sformatf("v%0d_done", v), done, vecs[v].exp_done);
            chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_hold_end", v), cpu_hold, 0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_ready_idle", v), in_ready, 0);
            chk($sformatf("v%0d_nwrites", v), wa.size(), 32'(vecs[v].exp_wr));
            errs = 0;
            for (int k = 0; k < wa.size(); k++) begin
                if (wa[k] !== 32'(k) || wd[k] !== vecs[v].pay[8*k +: 8]) errs++;
            end
            chk($sformatf("v%0d_contents", v), errs, 0);
            if (!vecs[v].gaps && wa.size() > 1)
                chk($sformatf("v%0d_b2b", v), wc[wc.size()-1] - wc[0], wa.size() - 1);
        end

        // ---- start pulsed during LEN must be ignored ----
        wa.delete(); wd.delete(); wc.delete();
        pulse_start();
        send(8'h02);
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        send(8'hAA); send(8'h55); send(8'hFF);
        chk("sb_done", done, 1);
        chk("sb_error", error, 0);
        repeat (2) @(negedge clk);
        chk("sb_nwrites", wa.size(), 2);
        chk("sb_w1", {wa[1], 24'h0, wd[1]}, {32'd1, 24'h0, 8'h55});

        // ---- reset after three payload bytes ----
        wa.delete(); wd.delete(); wc.delete();
        pulse_start();
        send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        rst = 1'b1;
        #1;
        chk("mid_hold_rst", cpu_hold, 1);
        @(negedge clk);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_mem_we", mem_we, 0);
        chk("mid_mem_addr", mem_addr, 0);
        chk("mid_mem_wdata", mem_wdata, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done_err", {done, error}, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h44;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("mid_nwrites", wa.size(), 3);
        chk("mid_in_ready_idle", in_ready, 0);

        // ---- full-memory load: len = MEM_NBYTE, byte i = i[7:0], csum 0 ----
        wa.delete(); wd.delete(); wc.delete();
        pulse_start();
        send(8'h00); send(8'h10); send(8'h00); send(8'h00);
        for (i = 0; i < 4096; i++) send(i[7:0]);
        send(8'h00);
        chk("full_done", done, 1);
        chk("full_error", error, 0);
        repeat (2) @(negedge clk);
        chk("full_nwrites", wa.size(), 4096);
        errs = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] !== 32'(k) || wd[k] !== 8'(k)) errs++;
        end
        chk("full_contents", errs, 0);
        chk("full_last_addr", wa[wa.size()-1], 32'd4095);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer that fills the byte-addressed instruction memory from a byte stream before the core runs.
- Accepts a framed stream over a valid/ready handshake and writes each payload byte to the IMEM byte write port, little-endian order, starting at BASE_ADDR.
- Frame: 4-byte length (LSB first), payload bytes, 1 checksum byte.
- Holds the core in reset (cpu_hold) while loading; reports done or error.

Parameters:
MEM_NBYTE, 4096, size of instruction memory in bytes
BASE_ADDR, 0, byte address of first payload byte

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load; ignored while busy
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  IMEM byte write enable
mem_addr  output  32  IMEM byte address
mem_wdata  output  8  IMEM byte data
busy  output  1  load in progress
done  output  1  sticky: last load completed with good checksum
error  output  1  sticky: last load failed (length or checksum)
cpu_hold  output  1  core reset request; equals busy OR rst

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, byte counters and checksum cleared. rst mid-load aborts immediately; no further writes; memory contents left as written.
- Byte accepted on an edge where in_valid && in_ready. in_data must be held while in_valid && !in_ready; in_ready never depends on in_valid.
- States:
  IDLE: in_ready=0. start=1 -> LEN; clears done, error, checksum, counters.
  LEN: in_ready=1. Shift 4 accepted bytes into len[31:0], first byte = bits 7:0. After 4th byte: len > MEM_NBYTE-BASE_ADDR -> ERR; len==0 -> CSUM; else -> DATA.
  DATA: in_ready=1. Each accepted byte: next cycle mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+index, mem_wdata=byte; index increments; csum = csum + byte mod 256. After byte number len -> CSUM.
  CSUM: in_ready=1. Accepted byte == csum -> DONE, else -> ERR.
  DONE: done=1, busy=0, one cycle -> IDLE (done stays set).
  ERR: error=1, busy=0, one cycle -> IDLE (error stays set).
- Write latency: exactly 1 cycle from acceptance edge to mem_we high; back-to-back bytes yield back-to-back writes, full throughput 1 byte/cycle. Last data write completes while in CSUM.
- busy=1 in LEN, DATA, CSUM; cpu_hold=busy|rst (combinational).
- start while busy: ignored. start in same cycle as rst: rst wins.
- Addresses never wrap: length check guarantees BASE_ADDR+len <= MEM_NBYTE; mem_addr max = MEM_NBYTE-1.
- Length check uses full 32-bit compare, no truncation.

Test Plan:
- Basic load: start, stream 08 00 00 00, 13 00 00 00 93 00 50 00, csum 0xF6 -> 8 writes at addr 0..7 with those bytes, done=1, error=0, cpu_hold falls after CSUM.
- Bad checksum: same frame with csum 0x00 -> 8 writes occur, error=1, done=0, state back to IDLE.
- Oversize length: len 0x00001001 with MEM_NBYTE=4096 -> error=1 after 4th length byte, zero writes, in_ready=0 afterwards.
- Zero length: 00 00 00 00, csum 00 -> no writes, done=1.
- Backpressure/gaps: in_valid toggled randomly during DATA of a 16-byte frame -> writes only on accepted bytes, addresses contiguous 0..15, csum correct, done=1.
- Reset mid-load: assert rst after 3 payload bytes -> next cycle all outputs zero, no further mem_we; subsequent full load succeeds with done=1.
